// File: rtl/bus_target.sv
// Wait-state bus responder for the 65C02: one 256-byte page, 240-byte RAM + register window.
// Define BUS_TARGET_TIMER_EN to add the interval timer (CTRL/RELOAD/COUNT/STATUS) that drives IRQ.
module bus_target #(
    parameter logic [7:0]  BASE = 8'hD0,
    parameter int unsigned WAIT = 1
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [15:0] AD,
    input  logic [7:0]  WD,
    input  logic        WE,
    output logic [7:0]  RD,
    output logic        SEL,
    output logic        RDY,
    output logic        IRQ
);
    localparam logic [2:0] WAIT_C   = 3'(WAIT);
    localparam logic [7:0] REG_BASE = 8'hF0;

    typedef enum logic {IDLE, STALL} state_t;

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       hit, commit;
    logic [7:0] off, reg_data, rdata;
    logic [7:0] ram [0:239];

    assign hit = (AD[15:8] == BASE);
    assign off = AD[7:0];

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A dropped hit while stalled aborts the access; the next hit starts a full stall again.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        RDY       = 1'b1;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (hit) begin
                    if (WAIT_C == 3'd0) begin
                        commit = 1'b1;
                    end else begin
                        RDY       = 1'b0;
                        state_nxt = STALL;
                        cnt_nxt   = 3'd1;
                    end
                end
            end
            STALL: begin
                if (!hit) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 3'd0;
                end else if (cnt == WAIT_C) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                    cnt_nxt   = 3'd0;
                end else begin
                    RDY     = 1'b0;
                    cnt_nxt = cnt + 3'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (commit && WE && (off < REG_BASE))
            ram[off] <= WD;
    end

`ifdef BUS_TARGET_TIMER_EN
    logic       en, ie, flag, irq_q, expire;
    logic       wr_ctrl, wr_reload, clr_flag;
    logic [7:0] reload, count;

    assign wr_ctrl   = commit && WE && (off == 8'hF0);
    assign wr_reload = commit && WE && (off == 8'hF1);
    assign clr_flag  = commit && WE && (off == 8'hF3) && WD[0];
    assign expire    = en && (count == 8'd0);

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            en     <= 1'b0;
            ie     <= 1'b0;
            flag   <= 1'b0;
            irq_q  <= 1'b0;
            reload <= 8'h00;
            count  <= 8'h00;
        end else begin
            if (wr_ctrl) begin
                en <= WD[0];
                ie <= WD[1];
            end
            if (wr_reload)
                reload <= WD;
            // RELOAD is only sampled on enable and on expiry, so a running write waits for the next wrap.
            if (wr_ctrl && WD[0] && !en)
                count <= reload;
            else if (expire)
                count <= reload;
            else if (en)
                count <= count - 8'd1;
            flag  <= expire | (flag & ~clr_flag);
            irq_q <= flag & ie;
        end
    end

    always_comb begin
        reg_data = 8'h00;
        case (off)
            8'hF0:   reg_data = {6'b0, ie, en};
            8'hF1:   reg_data = reload;
            8'hF2:   reg_data = count;
            8'hF3:   reg_data = {7'b0, flag};
            default: reg_data = 8'h00;
        endcase
    end

    assign IRQ = irq_q;
`else
    assign reg_data = 8'h00;
    assign IRQ      = 1'b0;
`endif

    always_comb begin
        rdata = reg_data;
        if (off < REG_BASE)
            rdata = ram[off];
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            RD  <= 8'h00;
            SEL <= 1'b0;
        end else begin
            SEL <= commit && !WE;
            if (commit && !WE)
                RD <= rdata;
        end
    end

endmodule

// File: tb/tb_bus_target.sv
// Bench for bus_target: four instances (WAIT=0..3) share one stimulus stream and are checked
// every cycle against an access-age/expiry-schedule model, plus hand-computed literal checks.
module tb_bus_target;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] ad  = 16'h0000;
    logic [7:0]  wd  = 8'h00;
    logic        we  = 1'b0;
    logic [7:0]  rd  [N];
    logic        sel [N];
    logic        rdy [N];
    logic        irq [N];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        bus_target #(.BASE(8'hD0), .WAIT(g)) u_dut (
            .clk(clk), .RST(rst), .AD(ad), .WD(wd), .WE(we),
            .RD(rd[g]), .SEL(sel[g]), .RDY(rdy[g]), .IRQ(irq[g])
        );
    end

    // Model: an access commits once it has been hitting for WAIT cycles beyond its first.
    logic [7:0] m_mem    [N][256];
    int         m_age    [N];
    logic [7:0] m_rd     [N];
    logic       m_sel    [N];
    logic       m_irq    [N];
    logic       m_en     [N];
    logic       m_ie     [N];
    logic       m_flag   [N];
    logic [7:0] m_reload [N];
    longint     m_next   [N];
    longint     cyc = 0;
    logic       h, cm, fi;
    logic [7:0] o;

    function automatic logic [7:0] m_reg(input int k, input logic [7:0] a);
        logic [7:0] v;
        v = 8'h00;
`ifdef BUS_TARGET_TIMER_EN
        case (a)
            8'hF0: v = {6'b0, m_ie[k], m_en[k]};
            8'hF1: v = m_reload[k];
            8'hF2: v = m_en[k] ? 8'(m_next[k] - cyc) : 8'h00;
            8'hF3: v = {7'b0, m_flag[k]};
            default: v = 8'h00;
        endcase
`endif
        return v;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                m_age[k] = 0; m_rd[k] = 8'h00; m_sel[k] = 1'b0; m_irq[k] = 1'b0;
                m_en[k] = 1'b0; m_ie[k] = 1'b0; m_flag[k] = 1'b0;
                m_reload[k] = 8'h00; m_next[k] = 0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                h  = (ad[15:8] == 8'hD0);
                o  = ad[7:0];
                cm = h && (m_age[k] == k);
                m_age[k] = (h && !cm) ? m_age[k] + 1 : 0;
                m_sel[k] = cm && !we;
                if (cm && !we) m_rd[k] = (o < 8'hF0) ? m_mem[k][o] : m_reg(k, o);
                if (cm && we && o < 8'hF0) m_mem[k][o] = wd;
`ifdef BUS_TARGET_TIMER_EN
                fi = m_en[k] && (cyc == m_next[k]);
                m_irq[k]  = m_flag[k] & m_ie[k];
                m_flag[k] = fi | (m_flag[k] & !(cm && we && o == 8'hF3 && wd[0]));
                if (fi) m_next[k] = cyc + longint'(m_reload[k]) + 1;
                if (cm && we && o == 8'hF0) begin
                    if (wd[0] && !m_en[k]) m_next[k] = cyc + longint'(m_reload[k]) + 1;
                    m_en[k] = wd[0];
                    m_ie[k] = wd[1];
                end
                if (cm && we && o == 8'hF1) m_reload[k] = wd;
`endif
            end
            cyc++;
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            chk($sformatf("rdy[%0d]", k), 8'(rdy[k]),
                8'((ad[15:8] != 8'hD0) || (m_age[k] == k)));
            chk($sformatf("sel[%0d]", k), 8'(sel[k]), 8'(m_sel[k]));
            chk($sformatf("rd[%0d]", k), rd[k], m_rd[k]);
            chk($sformatf("irq[%0d]", k), 8'(irq[k]), 8'(m_irq[k]));
        end
    end

    task automatic drive(input logic [15:0] a, input logic w, input logic [7:0] d);
        ad = a; we = w; wd = d;
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic hold(input logic [15:0] a, input logic w, input logic [7:0] d, input int n);
        drive(a, w, d);
        repeat (n) nxt();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset rd2", rd[2], 8'h00);
        chk("reset sel2", 8'(sel[2]), 8'h00);
        chk("reset irq2", 8'(irq[2]), 8'h00);
        @(posedge clk); #1 rst = 1'b1;
        nxt();

        // WAIT=1 write then read of D012
        drive(16'hD012, 1'b1, 8'h5A);
        @(negedge clk); chk("w1 wr stall", 8'(rdy[1]), 8'h00); nxt();
        @(negedge clk); chk("w1 wr ready", 8'(rdy[1]), 8'h01); nxt();
        drive(16'hD012, 1'b0, 8'h00);
        @(negedge clk); chk("w1 rd stall", 8'(rdy[1]), 8'h00); nxt();
        @(negedge clk); chk("w1 rd ready", 8'(rdy[1]), 8'h01); nxt();
        drive(16'h0000, 1'b0, 8'h00);
        @(negedge clk); chk("w1 rd sel", 8'(sel[1]), 8'h01); chk("w1 rd data", rd[1], 8'h5A); nxt();

        // miss leaves WAIT=0 instance untouched
        drive(16'h1234, 1'b0, 8'h00);
        repeat (3) begin
            @(negedge clk); chk("miss rdy0", 8'(rdy[0]), 8'h01); chk("miss sel0", 8'(sel[0]), 8'h00); nxt();
        end
        chk("miss rd0 held", rd[0], 8'h5A);

        // WAIT=3 abort after two hit cycles
        hold(16'hD020, 1'b1, 8'h11, 4);
        drive(16'h0000, 1'b0, 8'h00); nxt();
        drive(16'hD020, 1'b1, 8'h99);
        @(negedge clk); chk("abort stall a", 8'(rdy[3]), 8'h00); nxt();
        @(negedge clk); chk("abort stall b", 8'(rdy[3]), 8'h00); nxt();
        drive(16'h0000, 1'b0, 8'h00);
        @(negedge clk); chk("abort rdy", 8'(rdy[3]), 8'h01); chk("abort sel", 8'(sel[3]), 8'h00); nxt();
        hold(16'hD020, 1'b0, 8'h00, 4);
        drive(16'h0000, 1'b0, 8'h00);
        @(negedge clk);
        chk("abort ram kept", rd[3], 8'h11);
        chk("abort w1 wrote", rd[1], 8'h99);
        nxt();

        // WAIT=2 read hit by reset in its second stall cycle
        hold(16'hD005, 1'b1, 8'hA5, 4);
        drive(16'h0000, 1'b0, 8'h00); nxt();
        drive(16'hD005, 1'b0, 8'h00); nxt();
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst rd2", rd[2], 8'h00);
        chk("rst sel2", 8'(sel[2]), 8'h00);
        chk("rst irq2", 8'(irq[2]), 8'h00);
        @(posedge clk); #3 rst = 1'b1;
        @(negedge clk); chk("rst restall a", 8'(rdy[2]), 8'h00); nxt();
        @(negedge clk); chk("rst restall b", 8'(rdy[2]), 8'h00); nxt();
        @(negedge clk); chk("rst ready", 8'(rdy[2]), 8'h01); nxt();
        drive(16'h0000, 1'b0, 8'h00);
        @(negedge clk); chk("rst rd sel", 8'(sel[2]), 8'h01); chk("rst rd data", rd[2], 8'hA5); nxt();

        // unmapped offset reads zero, write ignored
        hold(16'hD0F8, 1'b1, 8'hFF, 4);
        hold(16'hD0F8, 1'b0, 8'h00, 4);
        drive(16'h0000, 1'b0, 8'h00);
        @(negedge clk); chk("unmapped sel", 8'(sel[1]), 8'h01); chk("unmapped rd", rd[1], 8'h00); nxt();

`ifdef BUS_TARGET_TIMER_EN
        hold(16'hD0F1, 1'b1, 8'h03, 4);
        hold(16'hD0F0, 1'b1, 8'h03, 4);
        drive(16'h0000, 1'b0, 8'h00);
        repeat (10) nxt();
        @(negedge clk); chk("timer irq0", 8'(irq[0]), 8'h01); nxt();
        hold(16'hD0F1, 1'b0, 8'h00, 4);
        drive(16'h0000, 1'b0, 8'h00);
        @(negedge clk); chk("timer reload rd", rd[1], 8'h03); nxt();
        hold(16'hD0F2, 1'b0, 8'h00, 2);
        hold(16'hD0F3, 1'b1, 8'h01, 1);
        drive(16'h0000, 1'b0, 8'h00);
        repeat (12) nxt();
        hold(16'hD0F3, 1'b0, 8'h00, 4);
        drive(16'h0000, 1'b0, 8'h00);
        repeat (4) nxt();
`else
        hold(16'hD0F0, 1'b1, 8'h03, 4);
        for (int i = 0; i < 4; i++) begin
            hold(16'hD005, 1'b0, 8'h00, 4);
            hold(16'hD0F0 + 16'(i), 1'b0, 8'h00, 4);
            drive(16'h0000, 1'b0, 8'h00);
            @(negedge clk);
            chk($sformatf("notimer sel F%0d", i), 8'(sel[1]), 8'h01);
            chk($sformatf("notimer rd F%0d", i), rd[1], 8'h00);
            nxt();
        end
        repeat (8) nxt();
        @(negedge clk); chk("notimer irq0", 8'(irq[0]), 8'h00); nxt();
`endif

        repeat (3) nxt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bus_target.md
Name: bus_target

Overview:
- Memory-mapped responder for the 65C02 core's bus. It sits on AD/DO/WE and returns read data and RDY to the CPU.
- Decodes one 256-byte page. The page holds a 240-byte RAM and a small register window.
- Stretches each access it owns by inserting wait states through RDY.
- With the optional feature compiled in, it also provides an interval timer that drives the CPU's IRQ input.

Parameters:
- BASE, 8'hD0: AD[15:8] value that selects this block.
- WAIT, 1: wait states per access, 0..7.

Ports:
- clk  in  1  CPU clock. All state updates on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- AD  in  16  CPU address bus. Combinatorial from the CPU.
- WD  in  8  write data, from CPU DO.
- WE  in  1  write enable from the CPU.
- RD  out  8  read data, to the system DI mux. Registered.
- SEL  out  1  registered; 1 means RD is valid this cycle and the system mux must select it.
- RDY  out  1  to CPU RDY. 0 holds the CPU. Combinatorial.
- IRQ  out  1  interrupt request to the CPU. Registered.

Behaviour:
- Hit decode: hit = (AD[15:8] == BASE). Combinatorial. Offset o = AD[7:0].
- FSM states are IDLE and STALL, with a 3-bit counter cnt.
- IDLE, no hit: RDY=1, no access.
- IDLE, hit, WAIT=0: RDY=1; the access commits at this edge; stay in IDLE.
- IDLE, hit, WAIT>0: RDY=0; go to STALL with cnt=1.
- STALL, cnt<WAIT: RDY=0; cnt increments.
- STALL, cnt==WAIT: RDY=1; the access commits at this edge; return to IDLE with cnt=0.
- Address stability: the CPU holds AD/WE/WD while RDY=0. If hit drops during STALL, the access is aborted, nothing commits, and the FSM returns to IDLE.
- Commit, write (WE=1):
  - o<8'hF0: RAM[o] <= WD.
  - o>=8'hF0: register write.
- Commit, read (WE=0): RD <= RAM[o] or register value, and SEL <= 1, both taking effect in the next cycle. Read latency is therefore WAIT+1 cycles from the first hit cycle.
- SEL is 0 in every cycle that does not follow a read commit. When SEL=0, RD holds its last value.
- Back-to-back accesses: every access after a commit starts a fresh IDLE evaluation, including an access to the same address, so each access incurs the full WAIT.
- Unmapped offsets 8'hF4..8'hFF read 8'h00; writes to them are ignored.
- Reset (asynchronous, RST=0) forces:
  - FSM to IDLE, cnt=0;
  - RD=8'h00, SEL=0, IRQ=0;
  - all timer registers to 0.
- RAM contents are not reset.
- Reset asserted mid-STALL aborts the access with no commit.
- After reset deasserts, RDY follows hit again; a held address restarts a full stall.

Optional Feature:
- Macro: BUS_TARGET_TIMER_EN.
- With the macro defined, the register window is:
  - 8'hF0 CTRL: bit0 EN, bit1 IE; other bits read 0.
  - 8'hF1 RELOAD: read/write.
  - 8'hF2 COUNT: read-only.
  - 8'hF3 STATUS: bit0 FLAG; writing 1 to bit0 clears it.
- Timer behaviour:
  - A write that takes EN from 0 to 1 loads COUNT <= RELOAD.
  - While EN=1, COUNT decrements every clk.
  - When COUNT==0: COUNT <= RELOAD and FLAG <= 1.
  - RELOAD=0 sets FLAG every cycle.
  - Writing RELOAD while running takes effect at the next reload.
  - If FLAG is set and cleared in the same cycle, set wins.
- IRQ <= FLAG & IE, so IRQ lags FLAG by one cycle.
- Without the macro: F0..F3 read 8'h00, their writes are ignored, and IRQ is constant 0.

Test Plan:
- WAIT=1 write then read (write AD=16'hD012, WD=8'h5A; then read AD=16'hD012) -> each access: RDY=0 for exactly 1 cycle; the read gives SEL=1 and RD=8'h5A two cycles after the read's first hit cycle.
- WAIT=0 read of AD=16'h1234 (miss) -> RDY stays 1, SEL stays 0, RD unchanged.
- WAIT=3: drive AD to 16'hD020 for 2 cycles, then to 16'h0000 -> RDY=0 for 2 cycles, then 1; RAM[8'h20] unchanged; SEL=0 throughout.
- WAIT=2 read stall: pull RST low in the second stall cycle, release with AD still 16'hD005 -> immediately RD=0, SEL=0, IRQ=0; after release RDY=0 for 2 more cycles, then a normal read completes.
- Timer (macro on): write RELOAD=8'h03, CTRL=8'h03 -> FLAG sets every 4 cycles and IRQ follows one cycle later; writing STATUS=8'h01 clears IRQ until the next expiry.
- Timer (macro off): read 8'hF0..8'hF3 -> 8'h00; IRQ stays 0 after writing CTRL=8'h03.
